// File: rtl/fc_argmax_8_16_pkg.sv
// Shared types and sizing for the FC-layer argmax stage.
package fc_argmax_8_16_pkg;

  localparam int FC_M     = 8;
  localparam int FC_T     = 16;
  localparam int FC_F     = 8;
  localparam int FC_IDX_W = $clog2(FC_M);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/fc_argmax_8_16_counter.sv
// Modulo counter: counts enabled cycles from 0 to OF, flags OF and wraps to 0 on the next enable.
module counter #(
  parameter int OF = 7,
  parameter int W  = $clog2(OF + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_of
);

  logic [W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_of  = (r_cnt == W'(OF));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= {W{1'b0}};
    end else if (i_en) begin
      r_cnt <= o_of ? {W{1'b0}} : (r_cnt + W'(1));
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/fc_argmax_8_16.sv
// Argmax over each M-element frame from the final FC layer; one held result per frame
// with a wrapping frame sequence number.
module fc_argmax_8_16
  import fc_argmax_8_16_pkg::*;
#(
  parameter int M = FC_M,
  parameter int T = FC_T,
  parameter int F = FC_F
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic [T-1:0]         input_data,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic [$clog2(M)-1:0] output_index,
  output logic [T-1:0]         output_value,
  output logic [F-1:0]         output_frame
);

  localparam int IW = $clog2(M);

  state_e                r_state;
  logic signed [T-1:0]   r_best_val;
  logic [IW-1:0]         r_best_idx;
  logic                  r_out_valid;
  logic [IW-1:0]         r_out_index;
  logic [T-1:0]          r_out_value;
  logic [F-1:0]          r_out_frame;

  logic                  w_accept;
  logic [IW-1:0]         w_cnt;
  logic                  w_last;
  logic                  w_take;
  logic signed [T-1:0]   w_new_val;
  logic [IW-1:0]         w_new_idx;

  assign w_accept = input_valid && input_ready;

  counter #(
    .OF (M - 1),
    .W  (IW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_accept),
    .o_cnt (w_cnt),
    .o_of  (w_last)
  );

  // First element always seeds the best; later ones replace it only if strictly larger,
  // so ties keep the lowest index.
  assign w_take    = (w_cnt == {IW{1'b0}}) || ($signed(input_data) > r_best_val);
  assign w_new_val = w_take ? $signed(input_data) : r_best_val;
  assign w_new_idx = w_take ? w_cnt : r_best_idx;

  assign output_valid = r_out_valid;
  assign output_index = r_out_index;
  assign output_value = r_out_value;
  assign output_frame = r_out_frame;

  always_comb begin
    input_ready = 1'b0;
    if (reset) begin
      input_ready = 1'b0;
    end else if (r_state == ST_ACCUM) begin
      input_ready = 1'b1;
    end else begin
      input_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_ACCUM;
      r_best_val  <= {T{1'b0}};
      r_best_idx  <= {IW{1'b0}};
      r_out_valid <= 1'b0;
      r_out_index <= {IW{1'b0}};
      r_out_value <= {T{1'b0}};
      r_out_frame <= {F{1'b0}};
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_best_val <= w_new_val;
            r_best_idx <= w_new_idx;
            // The result must include the element accepted on this same edge.
            if (w_last) begin
              r_out_index <= w_new_idx;
              r_out_value <= w_new_val;
              r_out_valid <= 1'b1;
              r_state     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (r_out_valid && output_ready) begin
            r_out_valid <= 1'b0;
            r_out_frame <= r_out_frame + F'(1);
            r_state     <= ST_ACCUM;
          end
        end
        default: begin
          r_state     <= ST_ACCUM;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax_8_16.sv
// Self-checking bench for fc_argmax_8_16: frame-level argmax model plus directed literal checks.
module tb_fc_argmax_8_16;

  typedef int frame_t [8];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        input_valid = 1'b0;
  logic        input_ready;
  logic [15:0] input_data = 16'd0;
  logic        output_valid;
  logic        output_ready = 1'b1;
  logic [2:0]  output_index;
  logic [15:0] output_value;
  logic [7:0]  output_frame;

  int n_tests = 0;
  int n_fail  = 0;

  fc_argmax_8_16 dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_index (output_index),
    .output_value (output_value),
    .output_frame (output_frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: collects accepted elements, produces the frame result after the 8th.
  int  m_elems[$];
  bit  m_hold = 1'b0;
  bit  m_post_reset = 1'b0;
  int  m_frame = 0;
  int  m_exp_idx = 0;
  int  m_exp_val = 0;
  int  m_accepts = 0;

  always @(negedge clk) begin
    if (reset) begin
      check("ready_during_reset", int'(input_ready), 0);
      m_elems.delete();
      m_hold       = 1'b0;
      m_frame      = 0;
      m_post_reset = 1'b1;
    end else begin
      if (m_post_reset) begin
        check("reset_valid", int'(output_valid), 0);
        check("reset_index", int'(output_index), 0);
        check("reset_value", int'($signed(output_value)), 0);
        check("reset_frame", int'(output_frame), 0);
        m_post_reset = 1'b0;
      end
      check("input_ready", int'(input_ready), m_hold ? 0 : 1);
      check("output_valid", int'(output_valid), m_hold ? 1 : 0);
      if (m_hold) begin
        check("out_index", int'(output_index), m_exp_idx);
        check("out_value", int'($signed(output_value)), m_exp_val);
        check("out_frame", int'(output_frame), m_frame % 256);
      end
      if (!m_hold && input_valid) begin
        m_elems.push_back(int'($signed(input_data)));
        m_accepts++;
        if (m_elems.size() == 8) begin
          m_exp_idx = 0;
          m_exp_val = m_elems[0];
          for (int i = 1; i < 8; i++) begin
            if (m_elems[i] > m_exp_val) begin
              m_exp_val = m_elems[i];
              m_exp_idx = i;
            end
          end
          m_elems.delete();
          m_hold = 1'b1;
        end
      end else if (m_hold && output_ready) begin
        m_hold  = 1'b0;
        m_frame = m_frame + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input frame_t vals, input int gap, input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      input_valid = 1'b1;
      input_data  = 16'(vals[i]);
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        @(negedge clk);
        acc = input_ready;
        tick();
      end
      if (!acc) check("send_timeout", 0, 1);
      input_valid = 1'b0;
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) tick();
      end
    end
  endtask

  task automatic expect_result(input string name, input int idx, input int val, input int frm,
                               input int hold);
    bit got;
    int acc0;
    got = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (output_valid) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_seen"}, int'(got), 1);
    check({name, "_index"}, int'(output_index), idx);
    check({name, "_value"}, int'($signed(output_value)), val);
    check({name, "_frame"}, int'(output_frame), frm);
    if (hold > 0) begin
      acc0 = m_accepts;
      tick();
      input_valid = 1'b1;
      input_data  = 16'd100;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        tick();
      end
      @(negedge clk);
      check({name, "_hold_valid"}, int'(output_valid), 1);
      check({name, "_hold_ready"}, int'(input_ready), 0);
      check({name, "_hold_index"}, int'(output_index), idx);
      check({name, "_hold_value"}, int'($signed(output_value)), val);
      tick();
      output_ready = 1'b1;
      @(negedge clk);
      check({name, "_pre_hs_valid"}, int'(output_valid), 1);
      tick();
      input_valid = 1'b0;
      @(negedge clk);
      check({name, "_post_hs_valid"}, int'(output_valid), 0);
      check({name, "_post_hs_frame"}, int'(output_frame), (frm + 1) % 256);
      check({name, "_no_accepts"}, m_accepts - acc0, 0);
    end
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    frame_t f1;
    frame_t fr;
    int     a0;
    f1 = '{3, 9, 1, 9, 0, 2, 7, 5};

    do_reset();
    send(f1, 0, 8);
    expect_result("basic", 1, 9, 0, 0);

    do_reset();
    send('{-5, -3, -8, -3, -9, -4, -7, -6}, 0, 8);
    expect_result("negative", 1, -3, 0, 0);
    send('{0, 0, 0, 0, 0, 0, 0, 1}, 0, 8);
    expect_result("last_max", 7, 1, 1, 0);
    send('{-32768, 0, 0, 0, 0, 0, 0, 32767}, 0, 8);
    expect_result("extremes", 7, 32767, 2, 0);
    send('{0, 0, 0, 0, 0, 0, 0, 0}, 0, 8);
    expect_result("all_zero", 0, 0, 3, 0);

    output_ready = 1'b0;
    send(f1, 0, 8);
    expect_result("backpressure", 1, 9, 4, 10);

    a0 = m_accepts;
    send(f1, 1, 8);
    check("toggle_accepts", m_accepts - a0, 8);
    expect_result("toggle", 1, 9, 5, 0);

    send('{11, 22, 33, 44, 0, 0, 0, 0}, 0, 4);
    do_reset();
    send('{1, 2, 3, 4, 5, 6, 7, 8}, 0, 8);
    expect_result("after_reset", 7, 8, 0, 0);

    for (int f = 1; f < 256; f++) begin
      for (int i = 0; i < 8; i++) fr[i] = int'($urandom_range(65535)) - 32768;
      send(fr, 0, 8);
    end
    send('{-1, -1, -1, -1, -1, -1, -1, -1}, 0, 8);
    expect_result("wrap", 0, -1, 0, 0);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
